// File: rtl/final_project_score_entry_if.sv
// Score-entry bus: digit handshake, enter/clear controls, converted score
// and the per-digit echo used by the seven-segment decoders.
interface final_project_score_entry_if;
    logic       digit_valid;
    logic [3:0] digit;
    logic       ready;
    logic       enter;
    logic       clear;
    logic [6:0] value;
    logic       value_valid;
    logic       error;
    logic [1:0] count;
    logic [3:0] disp_d0;
    logic [3:0] disp_d1;
    logic [3:0] disp_d2;

    modport master (
        output digit_valid, digit, enter, clear,
        input  ready, value, value_valid, error, count,
        input  disp_d0, disp_d1, disp_d2
    );

    modport slave (
        input  digit_valid, digit, enter, clear,
        output ready, value, value_valid, error, count,
        output disp_d0, disp_d1, disp_d2
    );
endinterface

// File: rtl/final_project_score_entry.sv
// Decimal score-entry decoder: accumulates up to MAX_DIGITS BCD digits
// (most significant first) into a 7-bit binary score and echoes the typed
// digits for display.
// Optional feature macro SCORE_ENTRY_CLAMP_EN: when defined, an entry larger
// than MAX_VALUE saturates to MAX_VALUE instead of entering the error state.
module final_project_score_entry #(
    parameter int MAX_DIGITS = 3,
    parameter int MAX_VALUE  = 127
) (
    input logic                         clk,
    input logic                         rst,
    final_project_score_entry_if.slave  bus
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);
    localparam logic [9:0] MAX_ACC = 10'(MAX_VALUE);
    localparam logic [6:0] MAX_VAL = 7'(MAX_VALUE);

    typedef enum logic [1:0] {EMPTY, ENTRY, CONVERT, ERR} state_t;

    state_t     state;
    logic [9:0] acc;
    logic [1:0] count;
    logic [6:0] value;
    logic       value_valid;
    logic       error;
    logic [3:0] disp_d0;
    logic [3:0] disp_d1;
    logic [3:0] disp_d2;

    logic       ready;
    logic       take;
    logic       legal;
    logic [9:0] acc_base;
    logic [9:0] acc_next;

    // ready comes only from registered state so the front end sees no
    // combinational path from its own inputs.
    assign ready    = (state == EMPTY) || ((state == ENTRY) && (count < MAX_CNT));
    assign take     = bus.digit_valid && ready;
    assign legal    = (bus.digit <= 4'd9);
    // The first digit of an entry starts from zero, discarding any leftover.
    assign acc_base = (state == EMPTY) ? 10'd0 : acc;
    assign acc_next = (acc_base << 3) + (acc_base << 1) + {6'd0, bus.digit};

    assign bus.ready       = ready;
    assign bus.value       = value;
    assign bus.value_valid = value_valid;
    assign bus.error       = error;
    assign bus.count       = count;
    assign bus.disp_d0     = disp_d0;
    assign bus.disp_d1     = disp_d1;
    assign bus.disp_d2     = disp_d2;

    // Entry state machine: digit accumulation, conversion and error handling,
    // with clear overriding everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            acc         <= 10'd0;
            count       <= 2'd0;
            value       <= 7'd0;
            value_valid <= 1'b0;
            error       <= 1'b0;
            disp_d0     <= 4'd0;
            disp_d1     <= 4'd0;
            disp_d2     <= 4'd0;
        end else begin
            value_valid <= 1'b0;
            if (bus.clear) begin
                state   <= EMPTY;
                acc     <= 10'd0;
                count   <= 2'd0;
                error   <= 1'b0;
                disp_d0 <= 4'd0;
                disp_d1 <= 4'd0;
                disp_d2 <= 4'd0;
            end else begin
                case (state)
                    EMPTY, ENTRY: begin
                        if (take && !legal) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            if (take) begin
                                acc     <= acc_next;
                                count   <= (state == EMPTY) ? 2'd1 : count + 2'd1;
                                disp_d2 <= (state == EMPTY) ? 4'd0 : disp_d1;
                                disp_d1 <= (state == EMPTY) ? 4'd0 : disp_d0;
                                disp_d0 <= bus.digit;
                                state   <= ENTRY;
                            end
                            if (bus.enter && (state == ENTRY)) begin
                                state <= CONVERT;
                            end
                        end
                    end
                    CONVERT: begin
                        if (acc <= MAX_ACC) begin
                            value       <= acc[6:0];
                            value_valid <= 1'b1;
                            count       <= 2'd0;
                            state       <= EMPTY;
                        end else begin
`ifdef SCORE_ENTRY_CLAMP_EN
                            value       <= MAX_VAL;
                            value_valid <= 1'b1;
                            count       <= 2'd0;
                            state       <= EMPTY;
`else
                            state <= ERR;
                            error <= 1'b1;
`endif
                        end
                    end
                    ERR: begin
                        state <= ERR;
                    end
                    default: begin
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_final_project_score_entry.sv
// Directed testbench for final_project_score_entry.
module tb_final_project_score_entry;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    final_project_score_entry_if bus();

    final_project_score_entry #(.MAX_DIGITS(3), .MAX_VALUE(127)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        step();
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
    endtask

    task automatic press_enter();
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
    endtask

    task automatic press_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.digit_valid = 1'b0; bus.digit = 4'd0; bus.enter = 1'b0; bus.clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        tests_run++; if (bus.value !== 7'd0) begin tests_failed++; $display("[TB] FAIL rst_value got %0d want 0", bus.value); end
        tests_run++; if (bus.value_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_vv got %b want 0", bus.value_valid); end
        tests_run++; if (bus.error !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_error got %b want 0", bus.error); end
        tests_run++; if (bus.count !== 2'd0) begin tests_failed++; $display("[TB] FAIL rst_count got %0d want 0", bus.count); end
        tests_run++; if (bus.ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_ready got %b want 1", bus.ready); end
        tests_run++; if ({bus.disp_d2, bus.disp_d1, bus.disp_d0} !== 12'h000) begin tests_failed++; $display("[TB] FAIL rst_disp got %h want 000", {bus.disp_d2, bus.disp_d1, bus.disp_d0}); end
    endtask

    task automatic test_convert_127();
        send_digit(4'd1);
        tests_run++; if (bus.count !== 2'd1) begin tests_failed++; $display("[TB] FAIL c127_count1 got %0d want 1", bus.count); end
        send_digit(4'd2);
        send_digit(4'd7);
        tests_run++; if (bus.count !== 2'd3) begin tests_failed++; $display("[TB] FAIL c127_count3 got %0d want 3", bus.count); end
        tests_run++; if (bus.ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL c127_full_ready got %b want 0", bus.ready); end
        tests_run++; if ({bus.disp_d2, bus.disp_d1, bus.disp_d0} !== 12'h127) begin tests_failed++; $display("[TB] FAIL c127_disp got %h want 127", {bus.disp_d2, bus.disp_d1, bus.disp_d0}); end
        press_enter();
        tests_run++; if (bus.ready !== 1'b0 || bus.value_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL c127_convert_cycle ready=%b vv=%b want 0/0", bus.ready, bus.value_valid); end
        step();
        tests_run++; if (bus.value_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL c127_vv got %b want 1", bus.value_valid); end
        tests_run++; if (bus.value !== 7'd127) begin tests_failed++; $display("[TB] FAIL c127_value got %0d want 127", bus.value); end
        tests_run++; if (bus.count !== 2'd0 || bus.ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL c127_after count=%0d ready=%b want 0/1", bus.count, bus.ready); end
        tests_run++; if ({bus.disp_d2, bus.disp_d1, bus.disp_d0} !== 12'h127) begin tests_failed++; $display("[TB] FAIL c127_disp_hold got %h want 127", {bus.disp_d2, bus.disp_d1, bus.disp_d0}); end
        step();
        tests_run++; if (bus.value_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL c127_vv_pulse got %b want 0", bus.value_valid); end
    endtask

    task automatic test_overflow();
        send_digit(4'd1);
        tests_run++; if ({bus.disp_d2, bus.disp_d1} !== 8'h00) begin tests_failed++; $display("[TB] FAIL ovf_disp_cleared got %h want 00", {bus.disp_d2, bus.disp_d1}); end
        send_digit(4'd2);
        send_digit(4'd8);
        press_enter();
        step();
`ifdef SCORE_ENTRY_CLAMP_EN
        tests_run++; if (bus.value_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_clamp_vv got %b want 1", bus.value_valid); end
        tests_run++; if (bus.error !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_clamp_error got %b want 0", bus.error); end
        tests_run++; if (bus.value !== 7'd127) begin tests_failed++; $display("[TB] FAIL ovf_clamp_value got %0d want 127", bus.value); end
`else
        tests_run++; if (bus.value_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_vv got %b want 0", bus.value_valid); end
        tests_run++; if (bus.error !== 1'b1 || bus.ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_err error=%b ready=%b want 1/0", bus.error, bus.ready); end
        tests_run++; if (bus.value !== 7'd127) begin tests_failed++; $display("[TB] FAIL ovf_value_kept got %0d want 127", bus.value); end
`endif
        press_clear();
        // 999 must accumulate without wrapping and still overflow.
        send_digit(4'd9);
        send_digit(4'd9);
        send_digit(4'd9);
        tests_run++; if ({bus.disp_d2, bus.disp_d1, bus.disp_d0} !== 12'h999) begin tests_failed++; $display("[TB] FAIL n999_disp got %h want 999", {bus.disp_d2, bus.disp_d1, bus.disp_d0}); end
        press_enter();
        step();
`ifdef SCORE_ENTRY_CLAMP_EN
        tests_run++; if (bus.value_valid !== 1'b1 || bus.value !== 7'd127) begin tests_failed++; $display("[TB] FAIL n999_clamp vv=%b value=%0d want 1/127", bus.value_valid, bus.value); end
`else
        tests_run++; if (bus.error !== 1'b1 || bus.value !== 7'd127) begin tests_failed++; $display("[TB] FAIL n999_err error=%b value=%0d want 1/127", bus.error, bus.value); end
`endif
        press_clear();
        tests_run++; if (bus.error !== 1'b0 || bus.ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_clear error=%b ready=%b want 0/1", bus.error, bus.ready); end
    endtask

    task automatic test_enter_with_digit();
        send_digit(4'd4);
        bus.digit_valid = 1'b1;
        bus.digit       = 4'd2;
        bus.enter       = 1'b1;
        step();
        bus.digit_valid = 1'b0;
        bus.enter       = 1'b0;
        tests_run++; if (bus.ready !== 1'b0 || bus.disp_d0 !== 4'd2) begin tests_failed++; $display("[TB] FAIL ewd_convert ready=%b d0=%0d want 0/2", bus.ready, bus.disp_d0); end
        step();
        tests_run++; if (bus.value_valid !== 1'b1 || bus.value !== 7'd42) begin tests_failed++; $display("[TB] FAIL ewd_value vv=%b value=%0d want 1/42", bus.value_valid, bus.value); end
    endtask

    task automatic test_max_digits();
        send_digit(4'd1);
        send_digit(4'd0);
        send_digit(4'd0);
        send_digit(4'd5);
        tests_run++; if (bus.count !== 2'd3) begin tests_failed++; $display("[TB] FAIL max_count got %0d want 3", bus.count); end
        tests_run++; if ({bus.disp_d2, bus.disp_d1, bus.disp_d0} !== 12'h100) begin tests_failed++; $display("[TB] FAIL max_disp got %h want 100", {bus.disp_d2, bus.disp_d1, bus.disp_d0}); end
        press_enter();
        step();
        tests_run++; if (bus.value_valid !== 1'b1 || bus.value !== 7'd100) begin tests_failed++; $display("[TB] FAIL max_value vv=%b value=%0d want 1/100", bus.value_valid, bus.value); end
    endtask

    task automatic test_illegal_clear();
        send_digit(4'd9);
        send_digit(4'hA);
        tests_run++; if (bus.error !== 1'b1 || bus.ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL ill_err error=%b ready=%b want 1/0", bus.error, bus.ready); end
        tests_run++; if (bus.count !== 2'd1 || bus.disp_d0 !== 4'd9) begin tests_failed++; $display("[TB] FAIL ill_noacc count=%0d d0=%0d want 1/9", bus.count, bus.disp_d0); end
        press_enter();
        step();
        tests_run++; if (bus.error !== 1'b1 || bus.value_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ill_sticky error=%b vv=%b want 1/0", bus.error, bus.value_valid); end
        press_clear();
        tests_run++; if (bus.error !== 1'b0 || bus.ready !== 1'b1 || bus.count !== 2'd0) begin tests_failed++; $display("[TB] FAIL ill_clear error=%b ready=%b count=%0d want 0/1/0", bus.error, bus.ready, bus.count); end
        tests_run++; if ({bus.disp_d2, bus.disp_d1, bus.disp_d0} !== 12'h000 || bus.value !== 7'd100) begin tests_failed++; $display("[TB] FAIL ill_clear_disp disp=%h value=%0d want 000/100", {bus.disp_d2, bus.disp_d1, bus.disp_d0}, bus.value); end
        bus.clear = 1'b1;
        send_digit(4'd3);
        bus.clear = 1'b0;
        tests_run++; if (bus.count !== 2'd0 || bus.disp_d0 !== 4'd0) begin tests_failed++; $display("[TB] FAIL clr_digit count=%0d d0=%0d want 0/0", bus.count, bus.disp_d0); end
    endtask

    task automatic test_enter_empty();
        press_enter();
        tests_run++; if (bus.ready !== 1'b1 || bus.count !== 2'd0) begin tests_failed++; $display("[TB] FAIL ee_state ready=%b count=%0d want 1/0", bus.ready, bus.count); end
        step();
        tests_run++; if (bus.value_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ee_vv got %b want 0", bus.value_valid); end
        send_digit(4'd5);
        press_enter();
        step();
        tests_run++; if (bus.value_valid !== 1'b1 || bus.value !== 7'd5) begin tests_failed++; $display("[TB] FAIL ee_value5 vv=%b value=%0d want 1/5", bus.value_valid, bus.value); end
    endtask

    task automatic test_reset_mid();
        send_digit(4'd6);
        send_digit(4'd3);
        rst = 1'b1;
        #1;
        tests_run++; if (bus.value !== 7'd0 || bus.count !== 2'd0 || bus.ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmid_async value=%0d count=%0d ready=%b want 0/0/1", bus.value, bus.count, bus.ready); end
        tests_run++; if ({bus.disp_d2, bus.disp_d1, bus.disp_d0} !== 12'h000 || bus.error !== 1'b0) begin tests_failed++; $display("[TB] FAIL rmid_disp disp=%h error=%b want 000/0", {bus.disp_d2, bus.disp_d1, bus.disp_d0}, bus.error); end
        #1;
        rst = 1'b0;
        press_enter();
        step();
        tests_run++; if (bus.value_valid !== 1'b0 || bus.value !== 7'd0) begin tests_failed++; $display("[TB] FAIL rmid_enter vv=%b value=%0d want 0/0", bus.value_valid, bus.value); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_convert_127();
        test_overflow();
        test_enter_with_digit();
        test_max_digits();
        test_illegal_clear();
        test_enter_empty();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
